// File: rtl/rgb_float_pkg.sv
// Shared types and constants for the RGB8 -> fp32 stream converter.
package rgb_float_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int CH_W     = 8;

  // Packed pixel as it arrives on the input bus: {R, G, B}.
  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb8_t;

  // IEEE-754 single-precision word.
  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/u8_to_fp32.sv
// Exact 8-bit unsigned to fp32 conversion, split into two independent halves:
// a priority encoder (used in the first pipeline stage) and an exponent /
// mantissa packer (used in the second stage) that consumes the stored MSB index.
module u8_to_fp32
  import rgb_float_pkg::*;
(
  input  logic [CH_W-1:0] enc_v_i,
  output logic [2:0]      enc_msb_o,
  input  logic [CH_W-1:0] pack_v_i,
  input  logic [2:0]      pack_msb_i,
  output fp32_t           pack_fp_o
);

  logic [4:0]      shamt;
  logic [MANT_W:0] shifted;

  // Priority encoder: index of the most significant set bit (0 when v is 0).
  always_comb begin
    enc_msb_o = '0;
    for (int i = 0; i < CH_W; i++) begin
      if (enc_v_i[i]) enc_msb_o = 3'(i);
    end
  end

  // Normalise so the leading one lands on the hidden-bit position; the
  // mantissa is the 23 bits below it. Zero input maps to +0.0.
  always_comb begin
    shamt     = 5'd23 - {2'b00, pack_msb_i};
    shifted   = {{(MANT_W + 1 - CH_W){1'b0}}, pack_v_i} << shamt;
    pack_fp_o = '0;
    if (pack_v_i != '0) begin
      pack_fp_o.sign = 1'b0;
      pack_fp_o.exp  = 8'(EXP_BIAS) + {5'b00000, pack_msb_i};
      pack_fp_o.mant = shifted[MANT_W-1:0];
    end
  end

endmodule

// File: rtl/rgb8_to_float_stream.sv
// Two-stage streaming converter from packed RGB8 pixels to three fp32 words.
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high; ready may depend combinationally on the downstream ready, and a
// producer holds its payload stable while valid is high and ready is low.
module rgb8_to_float_stream
  import rgb_float_pkg::*;
#(
  parameter int PIXELS_PER_FRAME = 4096,
  parameter int CNT_W            = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic [31:0]      out_g,
  output logic [31:0]      out_b,
  output logic             out_last,
  output logic [CNT_W-1:0] pix_count
);

  rgb8_t pix_in;

  // Stage 1: raw pixel, per-channel MSB index, frame-end tag.
  logic       s1_valid_q, s1_valid_d;
  rgb8_t      s1_pix_q, s1_pix_d;
  logic [2:0] s1_msb_r_q, s1_msb_r_d;
  logic [2:0] s1_msb_g_q, s1_msb_g_d;
  logic [2:0] s1_msb_b_q, s1_msb_b_d;
  logic       s1_last_q, s1_last_d;

  // Stage 2: assembled floats, drives the output port directly.
  logic       s2_valid_q, s2_valid_d;
  fp32_t      s2_r_q, s2_r_d;
  fp32_t      s2_g_q, s2_g_d;
  fp32_t      s2_b_q, s2_b_d;
  logic       s2_last_q, s2_last_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       in_fire;
  logic       s1_advance;
  logic       cnt_at_end;
  logic [2:0] enc_r, enc_g, enc_b;
  fp32_t      pack_r, pack_g, pack_b;

  assign pix_in = rgb8_t'(in_pixel);

  // S1 may hand over when S2 is empty or S2 is draining this very cycle.
  assign s1_advance = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready   = ~s1_valid_q | s1_advance;
  assign in_fire    = in_valid & in_ready;
  assign cnt_at_end = (cnt_q == CNT_W'(PIXELS_PER_FRAME - 1));

  u8_to_fp32 u_cvt_r (
    .enc_v_i    (pix_in.r),
    .enc_msb_o  (enc_r),
    .pack_v_i   (s1_pix_q.r),
    .pack_msb_i (s1_msb_r_q),
    .pack_fp_o  (pack_r)
  );

  u8_to_fp32 u_cvt_g (
    .enc_v_i    (pix_in.g),
    .enc_msb_o  (enc_g),
    .pack_v_i   (s1_pix_q.g),
    .pack_msb_i (s1_msb_g_q),
    .pack_fp_o  (pack_g)
  );

  u8_to_fp32 u_cvt_b (
    .enc_v_i    (pix_in.b),
    .enc_msb_o  (enc_b),
    .pack_v_i   (s1_pix_q.b),
    .pack_msb_i (s1_msb_b_q),
    .pack_fp_o  (pack_b)
  );

  // Stage 1 next state: load on input transfer, empty when handed to S2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pix_d   = s1_pix_q;
    s1_msb_r_d = s1_msb_r_q;
    s1_msb_g_d = s1_msb_g_q;
    s1_msb_b_d = s1_msb_b_q;
    s1_last_d  = s1_last_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_pix_d   = pix_in;
      s1_msb_r_d = enc_r;
      s1_msb_g_d = enc_g;
      s1_msb_b_d = enc_b;
      s1_last_d  = cnt_at_end;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: take S1's contents, or empty once consumed downstream.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_r_d     = s2_r_q;
    s2_g_d     = s2_g_q;
    s2_b_d     = s2_b_q;
    s2_last_d  = s2_last_q;
    if (s1_advance) begin
      s2_valid_d = 1'b1;
      s2_r_d     = pack_r;
      s2_g_d     = pack_g;
      s2_b_d     = pack_b;
      s2_last_d  = s1_last_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Frame position counter: counts accepted pixels, wraps after the last one.
  always_comb begin
    cnt_d = cnt_q;
    if (in_fire) begin
      cnt_d = cnt_at_end ? '0 : cnt_q + 1'b1;
    end
  end

  // Pipeline and counter registers; reset discards everything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      s1_msb_r_q <= '0;
      s1_msb_g_q <= '0;
      s1_msb_b_q <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
      s2_g_q     <= '0;
      s2_b_q     <= '0;
      s2_last_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pix_q   <= s1_pix_d;
      s1_msb_r_q <= s1_msb_r_d;
      s1_msb_g_q <= s1_msb_g_d;
      s1_msb_b_q <= s1_msb_b_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_r_q     <= s2_r_d;
      s2_g_q     <= s2_g_d;
      s2_b_q     <= s2_b_d;
      s2_last_q  <= s2_last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_r     = s2_r_q;
  assign out_g     = s2_g_q;
  assign out_b     = s2_b_q;
  assign out_last  = s2_last_q & s2_valid_q;
  assign pix_count = cnt_q;

endmodule

// File: doc/rgb8_to_float_stream.md
Name: rgb8_to_float_stream

Overview:
- Streaming front-end that converts packed 8-bit RGB pixels into three IEEE-754 single-precision channel words (red, green, blue).
- Produces the float operands consumed by the RGB-to-gray datapath, replacing the offline redfloat/greenfloat/bluefloat file generation.
- Two-stage pipeline with valid/ready handshakes on both sides; full throughput is one pixel per clock.
- Tags the last pixel of each frame.

Parameters:
- PIXELS_PER_FRAME, 4096: pixels per frame; out_last marks pixel number PIXELS_PER_FRAME-1. Legal range is 1 to 2^20.
- CNT_W, 20: width of the pixel counter. Must satisfy 2^CNT_W >= PIXELS_PER_FRAME.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_pixel  in  24  packed pixel {R[23:16], G[15:8], B[7:0]}, unsigned.
- out_valid  out  1  float triple valid.
- out_ready  in  1  downstream accepts the triple this cycle.
- out_r  out  32  IEEE-754 single of R.
- out_g  out  32  IEEE-754 single of G.
- out_b  out  32  IEEE-754 single of B.
- out_last  out  1  set with the final pixel of a frame.
- pix_count  out  CNT_W  number of pixels accepted in the current frame.

Behaviour:
- Reset (synchronous, RST high at a clock edge):
  - out_valid=0, out_last=0, out_r/g/b=0, pix_count=0.
  - Both stage-valid flags are cleared.
  - in_ready reads 1 in the first cycle after RST deasserts.
  - Asserting RST mid-stream discards all in-flight pixels; no partial frame is reported.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - out_r/g/b/out_last stay stable while out_valid=1 and out_ready=0.
  - in_pixel may change freely when no transfer occurs.
- Pipeline:
  - S1 registers the pixel plus its three MSB positions and last tag. S2 registers the assembled floats and is the output register.
  - Each stage advances when its successor is empty or being consumed in the same cycle.
  - in_ready = !s1_valid | s1_advance. This is combinational from out_ready; a full stall back-pressures within the same cycle.
  - Latency: 2 clocks from the input transfer edge to out_valid=1, with out_ready held high.
  - With in_valid=out_ready=1 continuously, one triple is output per clock with no bubbles.
  - Ordering is strictly preserved; nothing is dropped or duplicated.
- Conversion, per channel, v in 0..255, exact with no rounding:
  - v=0 -> 0x00000000 (positive zero).
  - v!=0 -> p = index of the most significant 1 (0..7); sign=0; exponent=127+p; mantissa = (v << (23-p)) & 0x7FFFFF.
  - No NaN, Inf or denormal outputs are possible.
- Frame counter:
  - Increments on every input transfer.
  - When pix_count == PIXELS_PER_FRAME-1 at a transfer, that pixel is tagged last and the counter wraps to 0.
  - PIXELS_PER_FRAME=1 tags every pixel last.
  - The last tag travels with its pixel through S1/S2.
- Simultaneous events: a transfer into S1 and out of S2 in the same cycle is legal, and each stage updates in that cycle.
- Reset has priority over any handshake in the same cycle.

Decomposition:
- Shared package (rgb_float_pkg):
  - FP_W=32, EXP_BIAS=127, MANT_W=23, CH_W=8 constants.
  - rgb8_t packed struct {r,g,b}.
  - fp32_t packed struct {sign, exp[7:0], mant[22:0]}.
- Sub-module u8_to_fp32: combinational 8-bit unsigned to fp32 converter (priority encoder plus shift).
  - Instantiated three times, with its priority-encoder half used in S1 and its pack half in S2.
  - Alternatively, split the sub-module into two functions in the package.

Test Plan:
- Single pixel 0xFF6432 with out_ready=1 -> after 2 clocks out_r=0x437F0000, out_g=0x42C80000, out_b=0x42480000, out_valid one cycle.
- Pixels 0x000180, then 0xC8C8C8 -> first triple 0x00000000 / 0x3F800000 / 0x43000000; second 0x43480000 for all three channels.
- Exhaustive 0..255 on all channels with random valid/ready -> every float equals the reference real-to-bits conversion; count matches; order preserved.
- out_ready=0 for 5 cycles while 3 pixels offered -> only 2 accepted, in_ready=0 afterwards, outputs held stable; release -> drains in order at 1/clk.
- PIXELS_PER_FRAME=4, stream of 9 pixels -> out_last on pixels 4 and 8 (1-based), pix_count wraps 3->0, pixel 9 not last.
- RST asserted with both stages full -> next cycle out_valid=0, pix_count=0, in_ready=1; the pixel after reset is counted as frame position 0.
